wr_stream_ctrl: RTL and testbench
=================================

Name: wr_stream_ctrl

Overview:
Write-side front end of the asynchronous FIFO, in the wclk domain, directly upstream of the write-pointer/full block. It accepts a valid/ready stream from the producer through a 2-entry skid buffer and drives winc/wdata into the pointer block and the memory. It also turns the Gray write pointer and the synchronized Gray read pointer into a registered fill level and an almost_full flag. A sticky error flag records any pointer-distance corruption.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
DATASIZE, 8, data word width
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range 1..2**ADDRSIZE

Ports:
wclk  input  1  write-domain clock
wrst  input  1  asynchronous, active-high reset
s_valid  input  1  producer word valid
s_data  input  DATASIZE  producer word
s_ready  output  1  block can accept a word this cycle
full  input  1  registered full from write-pointer block
wptr  input  ADDRSIZE+1  Gray write pointer from write-pointer block
rptr_sync  input  ADDRSIZE+1  Gray read pointer, already 2-flop synchronized into wclk
winc  output  1  write request to pointer block/memory
wdata  output  DATASIZE  word written at current waddr
wlevel  output  ADDRSIZE+1  registered occupancy, 0..2**ADDRSIZE
almost_full  output  1  registered, wlevel >= AF_THRESH
ptr_err  output  1  sticky: pointer distance exceeded depth

Behaviour:
- Reset (wrst high, async assert): state=EMPTY, s_ready=0 during reset and 1 the first cycle after, winc=0, wdata=0, wlevel=0, almost_full=0, ptr_err=0. Skid contents are discarded. A reset mid-operation drops any buffered words with no flush.
- Skid FSM on state register {EMPTY, ONE, TWO}. Main register holds the word presented to the FIFO; skid register holds overflow.
- s_ready = (state != TWO). It is decoded from the state register only; there is no combinational path from full or s_valid.
- winc = (state != EMPTY) && !full. wdata = main register. A word is consumed (drain) when winc=1.
- accept = s_valid && s_ready.
- EMPTY: accept -> ONE, main<=s_data.
- ONE:
  - accept&&drain -> ONE, main<=s_data.
  - accept&&!drain -> TWO, skid<=s_data.
  - !accept&&drain -> EMPTY.
  - Otherwise hold.
- TWO:
  - drain -> ONE, main<=skid.
  - Otherwise hold.
  - s_valid is ignored in TWO.
- Ordering is strictly preserved, with no duplication or loss. Data registers do not load when accept=0.
- Latency: a word accepted in cycle N appears on winc/wdata in cycle N+1 (if not full).
- full rises the cycle after the last slot is written. winc is already gated by full, so there is no double write at the boundary.
- Level arithmetic:
  - wbin = gray2bin(wptr), rbin = gray2bin(rptr_sync).
  - diff = (wbin - rbin) mod 2**(ADDRSIZE+1), ADDRSIZE+1 bits unsigned.
  - Pointer wrap (e.g. 31->0 at ADDRSIZE=4) needs no special case.
- wlevel <= diff each cycle (1-cycle latency from pointer change). almost_full <= (diff >= AF_THRESH).
- wlevel is pessimistic: it may overstate occupancy by the synchronizer delay, never understate.
- If diff > 2**ADDRSIZE: ptr_err <= 1, held until reset. wlevel saturates to 2**ADDRSIZE and almost_full=1.
- Simultaneous write and read-pointer advance: wlevel reflects both on the next edge. There is no arbitration.

Decomposition:
- Package wr_stream_ctrl_pkg: state enum skid_state_t {EMPTY, ONE, TWO}, and a localparam helper for DEPTH = 2**ADDRSIZE.
- Sub-module gray2bin, parameterized width, purely combinational XOR-prefix. Instantiated twice (wptr, rptr_sync); reusable on the read side.

Test Plan:
- Reset: assert wrst mid-stream with state=TWO -> all outputs 0 immediately. After release, s_ready=1, wlevel=0, and the buffered words are never written.
- Streaming: full=0, s_valid held high with data 0x01..0x10 -> winc=1 every cycle from cycle 2. wdata sequence is 0x01..0x10, each one cycle after acceptance. s_ready stays 1.
- Backpressure: full=1 while two words 0xA5, 0x5A are offered -> state=TWO, s_ready=0, winc=0. Release full -> wdata 0xA5 then 0x5A on consecutive cycles, and s_ready returns 1 after the first drain.
- Level/almost_full (ADDRSIZE=4, AF_THRESH=12): drive Gray wptr for binary 11 with rptr_sync=0 -> wlevel=11, almost_full=0. Then wptr for 12 -> next cycle wlevel=12, almost_full=1.
- Wrap: wbin=2 (Gray 3), rbin=28 (Gray 18) -> wlevel=6, ptr_err=0.
- Corruption: wbin=20, rbin=0 -> ptr_err=1 and wlevel=16. Set wbin=rbin afterwards -> wlevel=0 but ptr_err stays 1 until wrst.

Source files
------------

// File: rtl/wr_stream_ctrl_pkg.sv
// wr_stream_ctrl_pkg: shared skid-buffer state type and FIFO depth helper.
package wr_stream_ctrl_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
  function automatic int unsigned depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction
endpackage

// File: rtl/wr_stream_ctrl_gray2bin.sv
// gray2bin: combinational Gray-to-binary conversion by XOR prefix from the MSB.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/wr_stream_ctrl.sv
// wr_stream_ctrl: write-side skid buffer feeding winc/wdata, plus registered fill level and error tracking.
module wr_stream_ctrl
  import wr_stream_ctrl_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int DATASIZE  = 8,
  parameter int AF_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                full,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   rptr_sync,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                almost_full,
  output logic                ptr_err
);
  localparam logic [ADDRSIZE:0] DEPTH_P = (ADDRSIZE+1)'(depth(ADDRSIZE));
  localparam logic [ADDRSIZE:0] AF_P    = (ADDRSIZE+1)'(AF_THRESH);
  skid_state_t         state, state_n;
  logic [DATASIZE-1:0] main_q, skid_q;
  logic                accept, load_in, load_skid, load_fwd;
  logic [ADDRSIZE:0]   wbin, rbin, diff, lvl;
  assign s_ready = !wrst && (state != TWO);
  assign winc    = (state != EMPTY) && !full;
  assign wdata   = main_q;
  assign accept  = s_valid && s_ready;
  always_comb begin
    state_n   = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    load_fwd  = 1'b0;
    case (state)
      EMPTY: begin
        state_n = accept ? ONE : EMPTY;
        load_in = accept;
      end
      ONE: begin
        state_n   = (accept && !winc) ? TWO : (!accept && winc) ? EMPTY : ONE;
        load_in   = accept && winc;
        load_skid = accept && !winc;
      end
      default: begin
        state_n  = winc ? ONE : TWO;
        load_fwd = winc;
      end
    endcase
  end
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (load_in) main_q <= s_data;
      else if (load_fwd) main_q <= skid_q;
      if (load_skid) skid_q <= s_data;
    end
  end
  gray2bin #(.W(ADDRSIZE+1)) u_wbin (.gray(wptr),      .bin(wbin));
  gray2bin #(.W(ADDRSIZE+1)) u_rbin (.gray(rptr_sync), .bin(rbin));
  // Modular subtraction makes pointer wrap transparent; anything beyond depth is corruption.
  assign diff = wbin - rbin;
  assign lvl  = (diff > DEPTH_P) ? DEPTH_P : diff;
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel      <= '0;
      almost_full <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      wlevel      <= lvl;
      almost_full <= lvl >= AF_P;
      ptr_err     <= ptr_err || (diff > DEPTH_P);
    end
  end
endmodule

// File: tb/tb_wr_stream_ctrl.sv
// tb_wr_stream_ctrl: directed checks of skid streaming, backpressure, level, wrap, corruption and reset.
module tb_wr_stream_ctrl;
  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       full = 1'b0;
  logic [4:0] wptr = '0;
  logic [4:0] rptr_sync = '0;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] wlevel;
  logic       almost_full;
  logic       ptr_err;
  int         errors = 0;
  int         checks = 0;
  wr_stream_ctrl #(.ADDRSIZE(4), .DATASIZE(8), .AF_THRESH(12)) dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .full(full), .wptr(wptr), .rptr_sync(rptr_sync), .winc(winc), .wdata(wdata),
    .wlevel(wlevel), .almost_full(almost_full), .ptr_err(ptr_err)
  );
  always #5 wclk = ~wclk;
  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask
  task automatic lvl(input string tag, input int l, input logic af, input logic pe);
    chk({tag, "_level"}, 32'(wlevel), 32'(l));
    chk({tag, "_af"}, 32'(almost_full), 32'(af));
    chk({tag, "_err"}, 32'(ptr_err), 32'(pe));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    lvl("rst", 0, 1'b0, 1'b0);
    wrst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(s_ready), 1);
    // streaming: every word shows up one cycle after acceptance
    s_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_data = 8'(k);
      tick();
      chk("stream_wdata", 32'(wdata), 32'(k));
      chk("stream_winc", 32'(winc), 1);
      chk("stream_ready", 32'(s_ready), 1);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(winc), 0);
    // backpressure
    full = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    tick();
    chk("bp_one_winc", 32'(winc), 0);
    chk("bp_one_ready", 32'(s_ready), 1);
    s_data = 8'h5A;
    tick();
    chk("bp_two_ready", 32'(s_ready), 0);
    chk("bp_two_winc", 32'(winc), 0);
    chk("bp_two_wdata", 32'(wdata), 32'hA5);
    s_data = 8'hEE;
    tick();
    chk("bp_hold_wdata", 32'(wdata), 32'hA5);
    s_valid = 1'b0;
    full = 1'b0;
    #1;
    chk("bp_rel_winc", 32'(winc), 1);
    chk("bp_rel_wdata0", 32'(wdata), 32'hA5);
    tick();
    chk("bp_rel_wdata1", 32'(wdata), 32'h5A);
    chk("bp_rel_winc1", 32'(winc), 1);
    chk("bp_rel_ready", 32'(s_ready), 1);
    tick();
    chk("bp_empty_winc", 32'(winc), 0);
    // level and almost_full threshold
    wptr = g(11);
    rptr_sync = g(0);
    tick();
    lvl("lvl11", 11, 1'b0, 1'b0);
    wptr = g(12);
    tick();
    lvl("lvl12", 12, 1'b1, 1'b0);
    wptr = g(16);
    tick();
    lvl("lvl16", 16, 1'b1, 1'b0);
    wptr = g(2);
    rptr_sync = g(28);
    tick();
    lvl("wrap", 6, 1'b0, 1'b0);
    wptr = g(20);
    rptr_sync = g(0);
    tick();
    lvl("corrupt", 16, 1'b1, 1'b1);
    wptr = g(5);
    rptr_sync = g(5);
    tick();
    lvl("sticky", 0, 1'b0, 1'b1);
    // reset while two words are buffered
    full = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hB1;
    tick();
    s_data = 8'hB2;
    tick();
    chk("pre_rst_ready", 32'(s_ready), 0);
    wrst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(s_ready), 0);
    chk("async_rst_winc", 32'(winc), 0);
    chk("async_rst_wdata", 32'(wdata), 0);
    lvl("async_rst", 0, 1'b0, 1'b0);
    s_valid = 1'b0;
    full = 1'b0;
    tick();
    wrst = 1'b0;
    tick();
    chk("rel_ready", 32'(s_ready), 1);
    for (int k = 0; k < 3; k++) begin
      chk("rel_no_write", 32'(winc), 0);
      tick();
    end
    lvl("rel", 0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
